uart_rotation_parser: RTL



---
 rtl/uart_rotation_parser.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rotation_parser.sv
// Line parser behind the UART receiver: turns "L<digits>\n" / "R<digits>\n" into
// direction+magnitude commands on a valid/ready port, with status counters.
module uart_rotation_parser #(
    parameter int DBITS      = 8,
    parameter int VALUE_BITS = 16,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_n,
    input  logic                  rx_char_received,
    input  logic [DBITS-1:0]      rx_byte,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_dir,
    output logic [VALUE_BITS-1:0] cmd_value,
    output logic                  cmd_sat,
    output logic [CNT_BITS-1:0]   line_count,
    output logic [CNT_BITS-1:0]   err_count,
    output logic [CNT_BITS-1:0]   overrun_count,
    output logic                  eot_seen
);
    localparam int AW = VALUE_BITS + 4;
    localparam logic [DBITS-1:0] C_L   = DBITS'(8'h4C);
    localparam logic [DBITS-1:0] C_R   = DBITS'(8'h52);
    localparam logic [DBITS-1:0] C_CR  = DBITS'(8'h0D);
    localparam logic [DBITS-1:0] C_LF  = DBITS'(8'h0A);
    localparam logic [DBITS-1:0] C_SP  = DBITS'(8'h20);
    localparam logic [DBITS-1:0] C_EOT = DBITS'(8'h04);
    localparam logic [DBITS-1:0] C_0   = DBITS'(8'h30);
    localparam logic [DBITS-1:0] C_9   = DBITS'(8'h39);
    localparam logic [VALUE_BITS-1:0] VMAX = {VALUE_BITS{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_DIGITS, S_ERROR} state_t;

    state_t                r_state;
    logic [VALUE_BITS-1:0] r_acc;
    logic                  r_acc_sat;
    logic                  r_seen;
    logic                  r_line_dir;
    logic                  r_valid;
    logic                  r_dir;
    logic [VALUE_BITS-1:0] r_value;
    logic                  r_sat;
    logic [CNT_BITS-1:0]   r_lines;
    logic [CNT_BITS-1:0]   r_errs;
    logic [CNT_BITS-1:0]   r_overruns;
    logic                  r_eot;

    logic          w_is_digit;
    logic [AW-1:0] w_digit;
    logic [AW-1:0] w_acc_next;
    logic          w_over;
    logic          w_fire;
    logic          w_free;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign w_is_digit = (rx_byte >= C_0) && (rx_byte <= C_9);
    assign w_digit    = AW'(rx_byte - C_0);
    // Wide accumulate so overflow of the VALUE_BITS result is detectable.
    assign w_acc_next = {4'b0000, r_acc} * AW'(10) + w_digit;
    assign w_over     = w_acc_next > AW'(VMAX);
    assign w_fire     = r_valid && cmd_ready;
    assign w_free     = !r_valid || cmd_ready;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_acc_sat  <= 1'b0;
            r_seen     <= 1'b0;
            r_line_dir <= 1'b0;
            r_valid    <= 1'b0;
            r_dir      <= 1'b0;
            r_value    <= '0;
            r_sat      <= 1'b0;
            r_lines    <= '0;
            r_errs     <= '0;
            r_overruns <= '0;
            r_eot      <= 1'b0;
        end else begin
            if (w_fire) r_valid <= 1'b0;
            if (rx_char_received) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (rx_byte == C_L || rx_byte == C_R) begin
                            r_state    <= S_DIGITS;
                            r_line_dir <= (rx_byte == C_R);
                            r_acc      <= '0;
                            r_acc_sat  <= 1'b0;
                            r_seen     <= 1'b0;
                        end else if (rx_byte == C_EOT) begin
                            r_eot <= 1'b1;
                        end else if (rx_byte != C_CR && rx_byte != C_LF && rx_byte != C_SP) begin
                            r_state <= S_ERROR;
                            r_errs  <= sat_inc(r_errs);
                        end
                    end
                    S_DIGITS: begin
                        if (w_is_digit) begin
                            r_acc  <= w_over ? VMAX : w_acc_next[VALUE_BITS-1:0];
                            r_seen <= 1'b1;
                            if (w_over) r_acc_sat <= 1'b1;
                        end else if (rx_byte == C_LF) begin
                            r_state <= S_IDLE;
                            if (!r_seen) begin
                                r_errs <= sat_inc(r_errs);
                            end else if (w_free) begin
                                // Loading here overrides the handshake clear above.
                                r_valid <= 1'b1;
                                r_dir   <= r_line_dir;
                                r_value <= r_acc;
                                r_sat   <= r_acc_sat;
                                r_lines <= sat_inc(r_lines);
                            end else begin
                                r_overruns <= sat_inc(r_overruns);
                            end
                        end else if (rx_byte != C_CR) begin
                            r_state <= S_ERROR;
                            r_errs  <= sat_inc(r_errs);
                        end
                    end
                    S_ERROR: begin
                        if (rx_byte == C_LF) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_valid     = r_valid;
    assign cmd_dir       = r_dir;
    assign cmd_value     = r_value;
    assign cmd_sat       = r_sat;
    assign line_count    = r_lines;
    assign err_count     = r_errs;
    assign overrun_count = r_overruns;
    assign eot_seen      = r_eot;
endmodule
